// File: rtl/pixel_pkg.sv
// Shared types and default video timing for the pixel fetch path.
// Holds the fetch FSM state enum, the 30-bit RGB bundle and the 800x600 timing defaults.
package pixel_pkg;

    localparam int DEF_H_START = 216;
    localparam int DEF_H_ACT   = 800;
    localparam int DEF_V_START = 27;
    localparam int DEF_V_ACT   = 600;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_FRAME,
        ST_ACTIVE,
        ST_HOLD
    } fetch_state_e;

    typedef struct packed {
        logic [9:0] red;
        logic [9:0] green;
        logic [9:0] blue;
    } rgb_t;

endpackage

// File: rtl/rgb_unpack.sv
// Combinational unpack of two 16-bit SDRAM words into a 10-bit-per-channel RGB bundle.
// Ports: data_1_i {0,G[9:5],B}, data_2_i {0,G[4:0],R}, rgb_o unpacked colour.
module rgb_unpack
    import pixel_pkg::*;
(
    input  logic [15:0] data_1_i,
    input  logic [15:0] data_2_i,
    output rgb_t        rgb_o
);

    // Bit 15 of each word carries nothing.
    logic unused_msb;
    assign unused_msb = data_1_i[15] ^ data_2_i[15];

    always_comb begin
        rgb_o.red   = data_2_i[9:0];
        rgb_o.blue  = data_1_i[9:0];
        rgb_o.green = {data_1_i[14:10], data_2_i[14:10]};
    end

endmodule

// File: rtl/pixel_fetch.sv
// Frame-synchronous SDRAM pixel fetch with pause handling and a 2-cycle unpack pipeline.
// Ports: i_clk/i_rst, H/V timing counters, two SDRAM read words, i_CCD_pause in;
// read-FIFO pop, pixel valid, RGB, x/y, frame-start pulse, frame count and pause flag out.
module pixel_fetch
    import pixel_pkg::*;
#(
    parameter int H_START = DEF_H_START,
    parameter int H_ACT   = DEF_H_ACT,
    parameter int V_START = DEF_V_START,
    parameter int V_ACT   = DEF_V_ACT
)
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [12:0] i_H_Cont,
    input  logic [12:0] i_V_Cont,
    input  logic [15:0] i_sdram_data_1,
    input  logic [15:0] i_sdram_data_2,
    input  logic        i_CCD_pause,
    output logic        o_read_req,
    output logic        o_pix_valid,
    output logic [9:0]  o_Red,
    output logic [9:0]  o_Green,
    output logic [9:0]  o_Blue,
    output logic [9:0]  o_x,
    output logic [9:0]  o_y,
    output logic        o_frame_start,
    output logic [7:0]  o_frame_cnt,
    output logic        o_paused
);

    localparam logic [12:0] H_LO   = 13'(H_START);
    localparam logic [12:0] H_HI   = 13'(H_START + H_ACT);
    localparam logic [12:0] H_LAST = 13'(H_START + H_ACT - 1);
    localparam logic [12:0] V_LO   = 13'(V_START);
    localparam logic [12:0] V_HI   = 13'(V_START + V_ACT);
    localparam logic [12:0] V_LAST = 13'(V_START + V_ACT - 1);

    fetch_state_e state_q;

    logic        in_active;
    logic        at_origin;
    logic        at_last;
    logic        start_now;
    logic        read_req;
    logic [12:0] h_off;
    logic [12:0] v_off;
    logic        unused_off;

    assign in_active = (i_H_Cont >= H_LO) && (i_H_Cont < H_HI) &&
                       (i_V_Cont >= V_LO) && (i_V_Cont < V_HI);
    assign at_origin = (i_H_Cont == H_LO) && (i_V_Cont == V_LO);
    assign at_last   = (i_H_Cont == H_LAST) && (i_V_Cont == V_LAST);

    // The origin pixel is fetched in the same cycle the FSM decides to start,
    // so the request is opened one cycle before the state register shows ACTIVE.
    assign start_now = ((state_q == ST_WAIT_FRAME) || (state_q == ST_HOLD)) &&
                       at_origin && !i_CCD_pause;
    assign read_req  = in_active && ((state_q == ST_ACTIVE) || start_now);

    assign o_read_req = read_req;
    assign o_paused   = (state_q == ST_HOLD);

    assign h_off      = i_H_Cont - H_LO;
    assign v_off      = i_V_Cont - V_LO;
    assign unused_off = ^{h_off[12:10], v_off[12:10]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: state_q <= ST_WAIT_FRAME;
                ST_WAIT_FRAME,
                ST_HOLD: begin
                    if (at_origin) begin
                        state_q <= i_CCD_pause ? ST_HOLD : ST_ACTIVE;
                    end
                end
                // Pause is ignored here: a started frame always completes.
                ST_ACTIVE: begin
                    if (at_last) begin
                        state_q <= ST_WAIT_FRAME;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Stage 1: request tag and coordinates; SDRAM words arrive during this stage.
    logic       req_q;
    logic [9:0] x_q;
    logic [9:0] y_q;
    rgb_t       rgb_s1;

    rgb_unpack u_unpack (
        .data_1_i (i_sdram_data_1),
        .data_2_i (i_sdram_data_2),
        .rgb_o    (rgb_s1)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            req_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            req_q <= read_req;
            if (read_req) begin
                x_q <= h_off[9:0];
                y_q <= v_off[9:0];
            end
        end
    end

    // Stage 2: output registers, updated only for valid pixels.
    logic       valid_q;
    logic       fs_q;
    logic       fs_d;
    logic [7:0] cnt_q;
    rgb_t       rgb_q;
    logic [9:0] ox_q;
    logic [9:0] oy_q;

    assign fs_d = req_q && (x_q == 10'd0) && (y_q == 10'd0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            cnt_q   <= '0;
            rgb_q   <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
        end else begin
            valid_q <= req_q;
            fs_q    <= fs_d;
            if (fs_q) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (req_q) begin
                rgb_q <= rgb_s1;
                ox_q  <= x_q;
                oy_q  <= y_q;
            end
        end
    end

    assign o_pix_valid   = valid_q;
    assign o_frame_start = fs_q;
    assign o_frame_cnt   = cnt_q;
    assign o_Red         = rgb_q.red;
    assign o_Green       = rgb_q.green;
    assign o_Blue        = rgb_q.blue;
    assign o_x           = ox_q;
    assign o_y           = oy_q;

endmodule

// File: tb/tb_pixel_fetch.sv
// Scoreboard bench for pixel_fetch on a reduced raster (14x9 total, 8x5 active).
// Stimulus drives counters/data/pause and queues expected pixels; a monitor pops and compares.
module tb_pixel_fetch;

    localparam int HS = 3;
    localparam int HA = 8;
    localparam int HT = 14;
    localparam int VS = 2;
    localparam int VA = 5;
    localparam int VT = 9;

    typedef struct {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
        int         due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] hc;
    logic [12:0] vc;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        pause;

    logic        o_read_req;
    logic        o_pix_valid;
    logic [9:0]  o_Red;
    logic [9:0]  o_Green;
    logic [9:0]  o_Blue;
    logic [9:0]  o_x;
    logic [9:0]  o_y;
    logic        o_frame_start;
    logic [7:0]  o_frame_cnt;
    logic        o_paused;

    pixel_fetch #(
        .H_START (HS),
        .H_ACT   (HA),
        .V_START (VS),
        .V_ACT   (VA)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_H_Cont       (hc),
        .i_V_Cont       (vc),
        .i_sdram_data_1 (d1),
        .i_sdram_data_2 (d2),
        .i_CCD_pause    (pause),
        .o_read_req     (o_read_req),
        .o_pix_valid    (o_pix_valid),
        .o_Red          (o_Red),
        .o_Green        (o_Green),
        .o_Blue         (o_Blue),
        .o_x            (o_x),
        .o_y            (o_y),
        .o_frame_start  (o_frame_start),
        .o_frame_cnt    (o_frame_cnt),
        .o_paused       (o_paused)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model state, owned by the stimulus process.
    int   h = 0;
    int   v = 0;
    bit   armed = 0;
    bit   m_fetch = 0;
    bit   m_hold = 0;
    bit   prev_req = 0;
    int   px = 0;
    int   py = 0;
    int   n_fetch = 0;
    int   n_dir = 0;
    int   timeouts = 0;

    // Expectations handed to the monitor for the current cycle.
    bit   exp_rst = 1;
    bit   exp_req = 0;
    bit   exp_hold = 0;
    bit   final_chk = 0;

    logic [15:0] dir1 [2] = '{16'h7FFF, 16'h0000};
    logic [15:0] dir2 [2] = '{16'h0000, 16'h7C05};

    task automatic step(input bit r, input bit p);
        bit   origin;
        bit   act;
        bit   last;
        exp_t it;
        @(posedge clk);
        #1;
        if (h == HT - 1) begin
            h = 0;
            v = (v == VT - 1) ? 0 : v + 1;
        end else begin
            h = h + 1;
        end
        hc    = 13'(h);
        vc    = 13'(v);
        rst   = r;
        pause = p;
        if (prev_req && n_dir < 2) begin
            d1 = dir1[n_dir];
            d2 = dir2[n_dir];
            n_dir++;
        end else begin
            d1 = 16'($urandom);
            d2 = 16'($urandom);
        end
        if (r) begin
            armed    = 0;
            m_fetch  = 0;
            m_hold   = 0;
            prev_req = 0;
        end else if (prev_req) begin
            it.r   = 10'(int'(d2) % 1024);
            it.b   = 10'(int'(d1) % 1024);
            it.g   = 10'(((int'(d1) / 1024) % 32) * 32 + (int'(d2) / 1024) % 32);
            it.x   = 10'(px);
            it.y   = 10'(py);
            it.fs  = (px == 0) && (py == 0);
            it.due = cyc + 1;
            q.push_back(it);
        end
        origin = (h == HS) && (v == VS);
        act    = (h >= HS) && (h < HS + HA) && (v >= VS) && (v < VS + VA);
        last   = (h == HS + HA - 1) && (v == VS + VA - 1);
        exp_rst  = r;
        exp_hold = m_hold;
        if (!r && armed && origin && !m_fetch) begin
            m_fetch = !p;
            m_hold  = p;
            if (!p) n_fetch++;
        end
        exp_req  = m_fetch && act;
        prev_req = exp_req;
        px = h - HS;
        py = v - VS;
        if (m_fetch && last) m_fetch = 0;
        armed = !r;
    endtask

    always @(negedge clk) begin : mon
        exp_t        it;
        int          m_frames;
        int          pixcnt;
        logic [49:0] last_exp;
        if (exp_rst) begin
            q.delete();
            m_frames = 0;
            pixcnt   = -1;
            last_exp = '0;
            n_vec++;
            if ({o_pix_valid, o_read_req, o_paused, o_frame_start, o_frame_cnt,
                 o_Red, o_Green, o_Blue, o_x, o_y} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs cyc=%0d valid=%b req=%b cnt=%0d rgb=%h/%h/%h xy=%0d,%0d want all zero",
                         cyc, o_pix_valid, o_read_req, o_frame_cnt, o_Red, o_Green, o_Blue, o_x, o_y);
            end
        end else begin
            n_vec++;
            if (o_read_req !== exp_req) begin
                n_bad++;
                $display("FAIL read_req cyc=%0d H=%0d V=%0d got %b want %b", cyc, hc, vc, o_read_req, exp_req);
            end
            n_vec++;
            if (o_paused !== exp_hold) begin
                n_bad++;
                $display("FAIL paused cyc=%0d got %b want %b", cyc, o_paused, exp_hold);
            end
            if (o_pix_valid === 1'b1) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL pixel cyc=%0d unexpected valid x=%0d y=%0d want no pixel", cyc, o_x, o_y);
                end else begin
                    it = q.pop_front();
                    if ({o_Red, o_Green, o_Blue, o_x, o_y, o_frame_start} !==
                        {it.r, it.g, it.b, it.x, it.y, it.fs} || it.due != cyc) begin
                        n_bad++;
                        $display("FAIL pixel cyc=%0d got rgb=%h/%h/%h xy=%0d,%0d fs=%b want rgb=%h/%h/%h xy=%0d,%0d fs=%b at cyc %0d",
                                 cyc, o_Red, o_Green, o_Blue, o_x, o_y, o_frame_start,
                                 it.r, it.g, it.b, it.x, it.y, it.fs, it.due);
                    end
                    last_exp = {it.r, it.g, it.b, it.x, it.y};
                    if (it.fs) begin
                        n_vec++;
                        if (o_frame_cnt !== 8'(m_frames)) begin
                            n_bad++;
                            $display("FAIL frame_cnt cyc=%0d got %0d want %0d", cyc, o_frame_cnt, 8'(m_frames));
                        end
                        if (pixcnt >= 0) begin
                            n_vec++;
                            if (pixcnt != HA * VA) begin
                                n_bad++;
                                $display("FAIL frame_pixels got %0d want %0d", pixcnt, HA * VA);
                            end
                        end
                        m_frames++;
                        pixcnt = 0;
                    end
                    if (pixcnt >= 0) pixcnt++;
                end
            end else begin
                if (q.size() > 0 && q[0].due <= cyc) begin
                    it = q.pop_front();
                    n_vec++;
                    n_bad++;
                    $display("FAIL pixel cyc=%0d got no valid want x=%0d y=%0d", cyc, it.x, it.y);
                end
                n_vec++;
                if ({o_Red, o_Green, o_Blue, o_x, o_y, o_frame_start} !== {last_exp, 1'b0}) begin
                    n_bad++;
                    $display("FAIL hold cyc=%0d got %h fs=%b want %h fs=0",
                             cyc, {o_Red, o_Green, o_Blue, o_x, o_y}, o_frame_start, last_exp);
                end
            end
        end
        if (final_chk) begin
            n_vec++;
            if (o_frame_cnt !== 8'(m_frames)) begin
                n_bad++;
                $display("FAIL final_frame_cnt got %0d want %0d", o_frame_cnt, 8'(m_frames));
            end
            n_vec++;
            if (timeouts != 0) begin
                n_bad++;
                $display("FAIL wait_bound got %0d expired waits want 0", timeouts);
            end
        end
    end

    initial begin
        int  base;
        bit  cur_p;
        rst   = 1'b1;
        hc    = '0;
        vc    = '0;
        d1    = '0;
        d2    = '0;
        pause = 1'b0;

        repeat (3) step(1, 0);

        // Two clean frames from reset.
        repeat (2 * HT * VT + 10) step(0, 0);

        // Pause raised mid-frame: frame completes, next is skipped, then resumes.
        for (int i = 0; i < 400 && !(m_fetch && v == VS + 3); i++) step(0, 0);
        if (!(m_fetch && v == VS + 3)) timeouts++;
        for (int i = 0; i < 400 && !m_hold; i++) step(0, 1);
        if (!m_hold) timeouts++;
        repeat (30) step(0, 1);
        repeat (2 * HT * VT + 20) step(0, 0);

        // Reset pulse in the middle of a fetched frame.
        for (int i = 0; i < 400 && !(m_fetch && h == HS + 3 && v == VS + 2); i++) step(0, 0);
        if (!(m_fetch && h == HS + 3 && v == VS + 2)) timeouts++;
        step(1, 0);
        repeat (3 * HT * VT) step(0, 0);

        // Frame-count wrap with occasional random pauses.
        step(1, 0);
        base  = n_fetch;
        cur_p = 0;
        for (int i = 0; i < 60000 && (n_fetch - base) < 257; i++) begin
            if (h == HT - 1) cur_p = ($urandom % 12) == 0;
            step(0, cur_p);
        end
        if ((n_fetch - base) < 257) timeouts++;
        repeat (60) step(0, 0);

        final_chk = 1;
        @(negedge clk);
        #1;
        final_chk = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pixel_fetch.md
PIXEL_FETCH -- requirements
Module: pixel_fetch

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_START, 216: first active H_Cont value.
- H_ACT, 800: active pixels per line.
- V_START, 27: first active V_Cont value.
- V_ACT, 600: active lines per frame.
REQ-002 Ports (name, direction, width, meaning), one per line:
- i_clk, in, 1: single clock.
- i_rst, in, 1: reset, asynchronous, active-high.
- i_H_Cont, in, 13: horizontal timing counter.
- i_V_Cont, in, 13: vertical timing counter.
- i_sdram_data_1, in, 16: SDRAM read word 1, bits {1'b0, G[9:5], B[9:0]}.
- i_sdram_data_2, in, 16: SDRAM read word 2, bits {1'b0, G[4:0], R[9:0]}.
- i_CCD_pause, in, 1: freeze request from downstream processing.
- o_read_req, out, 1: SDRAM read-FIFO pop.
- o_pix_valid, out, 1: RGB/x/y valid.
- o_Red, out, 10: red.
- o_Green, out, 10: green.
- o_Blue, out, 10: blue.
- o_x, out, 10: pixel column.
- o_y, out, 10: pixel row.
- o_frame_start, out, 1: one-cycle pulse at the first pixel of each fetched frame.
- o_frame_cnt, out, 8: fetched-frame count.
- o_paused, out, 1: FSM is in HOLD.

Function
REQ-003 Active region: H_START <= i_H_Cont < H_START+H_ACT and V_START <= i_V_Cont < V_START+V_ACT; compare in 13 bits, no overflow.
REQ-004 FSM states: IDLE, WAIT_FRAME, ACTIVE, HOLD.
REQ-005 IDLE -> WAIT_FRAME one cycle after reset release, unconditionally.
REQ-006 WAIT_FRAME -> ACTIVE when i_H_Cont==H_START and i_V_Cont==V_START (frame origin) and i_CCD_pause==0.
REQ-007 WAIT_FRAME -> HOLD when the frame origin is reached with i_CCD_pause==1.
REQ-008 ACTIVE -> WAIT_FRAME on the cycle after the last active pixel (H_START+H_ACT-1, V_START+V_ACT-1).
REQ-009 i_CCD_pause asserted during ACTIVE has no effect until frame end; frames are never truncated.
REQ-010 HOLD -> ACTIVE at the next frame origin with i_CCD_pause==0; otherwise remain in HOLD.
REQ-011 o_paused is high exactly while in HOLD.
REQ-012 o_read_req is high only in ACTIVE (including the origin cycle) and inside the active region; it is never high in IDLE, WAIT_FRAME or HOLD.
REQ-013 SDRAM data is valid one cycle after o_read_req; it is captured on that cycle (stage 1) and registered to the outputs on the next (stage 2).
REQ-014 Total latency from o_read_req to o_pix_valid is exactly 2 cycles.
REQ-015 Unpack rules:
- o_Red = data_2[9:0].
- o_Blue = data_1[9:0].
- o_Green = {data_1[14:10], data_2[14:10]}.
- Bit 15 of both words is ignored.
REQ-016 o_x and o_y are i_H_Cont-H_START and i_V_Cont-V_START at request time, delayed 2 cycles to align with o_pix_valid.
REQ-017 o_frame_start is asserted together with o_pix_valid at o_x=0, o_y=0.
REQ-018 o_frame_cnt increments on each o_frame_start and wraps 255 -> 0.
REQ-019 When o_pix_valid==0, RGB/x/y hold their last values.
REQ-020 The pipeline drains in-flight pixels regardless of the state transition (e.g., entering HOLD never drops the last 2 pixels).

Reset
REQ-021 While i_rst is high:
- FSM = IDLE.
- All pipeline valid bits = 0.
- All outputs = 0, including o_frame_cnt and o_paused.
REQ-022 Reset asserted mid-frame clears in-flight pixels immediately; after release the next fetch starts only at a new frame origin.

Structure
REQ-023 Shared package pixel_pkg holds:
- fetch state enum.
- RGB struct (3x10 bits).
- Default timing constants (H_START, H_ACT, V_START, V_ACT).
REQ-024 One sub-module, rgb_unpack: purely combinational 2x16 -> RGB per REQ-015, used in stage 1.

Verification
REQ-025 Free-running 1056x628 counters from reset -> first o_read_req at H=216,V=27; o_pix_valid 2 cycles later with x=0,y=0 and o_frame_start=1.
REQ-026 data_1=16'h7FFF, data_2=16'h0000 -> R=0, G=10'h3E0, B=10'h3FF; data_1=16'h0000, data_2=16'h7C05 -> R=5, G=10'h01F, B=0.
REQ-027 i_CCD_pause=1 at line 300 of a frame -> frame completes with 480000 valid pixels; next frame is skipped with o_paused=1; pause dropped -> fetch resumes at the following origin.
REQ-028 256 frames fetched -> o_frame_cnt shows 255 then 0.
REQ-029 i_rst pulsed at x=400,y=100 -> o_pix_valid=0 within the reset cycle; no o_read_req until the next H=216,V=27.
REQ-030 Last pixel of a line (H=1015) -> o_x=799; H=1016 -> no request.
